// File: rtl/cmd_interp_pkg.sv
// Shared constants for the calculator command interpreter: opcode bytes,
// operation encodings, front-end FSM state codes and the opcode decoder.
package cmd_interp_pkg;

    localparam logic [7:0] OPC_ADD = 8'h2B;
    localparam logic [7:0] OPC_SUB = 8'h2D;
    localparam logic [7:0] OPC_MUL = 8'h2A;
    localparam logic [7:0] OPC_DIV = 8'h2F;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT_A = 2'd1;
    localparam logic [1:0] WAIT_B = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    typedef struct packed {
        logic       legal;
        logic [1:0] op;
    } opc_dec_t;

    function automatic opc_dec_t opc_decode(input logic [7:0] b);
        opc_dec_t d;
        d.legal = 1'b1;
        d.op    = OP_ADD;
        case (b)
            OPC_ADD: d.op = OP_ADD;
            OPC_SUB: d.op = OP_SUB;
            OPC_MUL: d.op = OP_MUL;
            OPC_DIV: d.op = OP_DIV;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cmd_interp_timeout.sv
// Inter-byte timeout counter: counts enabled cycles, flags expiry on the
// TIMEOUT_CYCLES-th one and restarts from zero. TIMEOUT_CYCLES = 0 disables it.
module cmd_interp_timeout #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

            logic [CNT_W-1:0] cnt;

            // expire marks the cycle whose end would be the limit-th idle cycle
            assign expire = en && (cnt == LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt <= '0;
                end else if (clr || expire) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/cmd_interp_in_ctrl.sv
// Command interpreter front-end: parses opcode/A/B byte frames from a
// valid/ready stream and drives the load1/load2 operand register strobes.
module cmd_interp_in_ctrl
    import cmd_interp_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] reg_data,
    output logic              load1,
    output logic              load2,
    output logic [1:0]        op,
    output logic              cmd_done,
    output logic              cmd_err,
    output logic              busy
);

    logic [1:0]        state, state_nx;
    logic [DATA_W-1:0] data_nx;
    logic [1:0]        op_nx;
    logic              load1_nx, load2_nx, done_nx, err_nx;
    logic              accept, legal;
    logic              tmo_en, tmo_clr, tmo_expire;
    opc_dec_t          dec;

    assign accept = rx_valid && rx_ready;
    assign dec    = opc_decode(rx_data[7:0]);
    // Wider buses only carry an opcode when the upper bits are zero
    assign legal  = dec.legal && ((rx_data >> 8) == '0);

    cmd_interp_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expire (tmo_expire)
    );

    always_comb begin
        state_nx = state;
        data_nx  = reg_data;
        op_nx    = op;
        load1_nx = 1'b0;
        load2_nx = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        tmo_en   = 1'b0;
        tmo_clr  = accept;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (legal) begin
                        op_nx    = dec.op;
                        state_nx = WAIT_A;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            WAIT_A, WAIT_B: begin
                // An accept on the limit cycle takes priority over the timeout
                if (accept) begin
                    data_nx  = rx_data;
                    load1_nx = (state == WAIT_A);
                    load2_nx = (state == WAIT_B);
                    state_nx = (state == WAIT_A) ? WAIT_B : DONE;
                end else begin
                    tmo_en = 1'b1;
                    if (tmo_expire) begin
                        err_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                done_nx  = 1'b1;
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rx_ready <= 1'b1;
            reg_data <= '0;
            load1    <= 1'b0;
            load2    <= 1'b0;
            op       <= OP_ADD;
            cmd_done <= 1'b0;
            cmd_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            rx_ready <= (state_nx != DONE);
            reg_data <= data_nx;
            load1    <= load1_nx;
            load2    <= load2_nx;
            op       <= op_nx;
            cmd_done <= done_nx;
            cmd_err  <= err_nx;
            busy     <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_cmd_interp_in_ctrl.sv
// Bench for cmd_interp_in_ctrl: directed frames plus random byte traffic,
// every output compared each cycle against a frame-position reference model.
module tb_cmd_interp_in_ctrl;

    localparam int DW = 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic [DW-1:0] reg_data;
    logic          load1, load2, cmd_done, cmd_err, busy;
    logic [1:0]    op;

    cmd_interp_in_ctrl #(
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .reg_data (reg_data),
        .load1    (load1),
        .load2    (load2),
        .op       (op),
        .cmd_done (cmd_done),
        .cmd_err  (cmd_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: position within a frame (0 opcode, 1 operand A,
    // 2 operand B, 3 stall after B) and idle cycles since the last byte.
    logic [7:0] opc_tab [4] = '{8'h2B, 8'h2D, 8'h2A, 8'h2F};
    int         m_pos, m_idle;
    logic [7:0] m_data;
    logic [1:0] m_op;
    logic       m_load1, m_load2, m_done, m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_idle = 0; m_data = 8'h00; m_op = 2'd0;
        m_load1 = 0; m_load2 = 0; m_done = 0; m_err = 0;
    endtask

    task automatic check_all();
        chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_pos != 3});
        chk("reg_data", {24'd0, reg_data}, {24'd0, m_data});
        chk("load1",    {31'd0, load1},    {31'd0, m_load1});
        chk("load2",    {31'd0, load2},    {31'd0, m_load2});
        chk("op",       {30'd0, op},       {30'd0, m_op});
        chk("cmd_done", {31'd0, cmd_done}, {31'd0, m_done});
        chk("cmd_err",  {31'd0, cmd_err},  {31'd0, m_err});
        chk("busy",     {31'd0, busy},     {31'd0, m_pos != 0});
    endtask

    task automatic model_advance(input bit acc, input logic [7:0] d);
        int idx;
        m_load1 = 0; m_load2 = 0; m_done = 0; m_err = 0;
        if (m_pos == 0) begin
            if (acc) begin
                idx = -1;
                for (int i = 0; i < 4; i++) if (opc_tab[i] == d) idx = i;
                if (idx >= 0) begin
                    m_op = 2'(idx); m_pos = 1; m_idle = 0;
                end else begin
                    m_err = 1;
                end
            end
        end else if (m_pos == 3) begin
            m_done = 1; m_pos = 0;
        end else if (acc) begin
            m_data = d; m_idle = 0;
            if (m_pos == 1) m_load1 = 1; else m_load2 = 1;
            m_pos = m_pos + 1;
        end else begin
            m_idle++;
            if (TO != 0 && m_idle == TO) begin
                m_err = 1; m_pos = 0; m_idle = 0;
            end
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, output bit acc);
        rx_valid = v;
        rx_data  = d;
        check_all();
        acc = v && (m_pos != 3);
        model_advance(acc, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, $urandom, a);
    endtask

    task automatic send(input logic [7:0] b);
        bit a;
        a = 0;
        for (int t = 0; t < 4 && !a; t++) step(1'b1, b, a);
        chk("send_accepted", {31'd0, a}, 32'd1);
    endtask

    initial begin
        bit a;
        logic [7:0] d;
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic add frame
        send(8'h2B); send(8'h05); send(8'h03); idle(3);
        // Illegal opcode, then a divide frame
        send(8'h41); idle(1);
        send(8'h2F); send(8'h08); send(8'h02); idle(3);
        // Timeout after operand A
        send(8'h2A); send(8'h07); idle(11);
        // Byte arriving on the last allowed idle cycle
        send(8'h2A); send(8'h07); idle(TO - 1); send(8'h05); idle(3);
        // Asynchronous reset while waiting for operand B
        send(8'h2B); send(8'h11);
        rx_valid = 1'b0;
        rst = 1'b1;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(8'h2D); send(8'h09); send(8'h04); idle(3);
        // Back-to-back frames, valid held high
        send(8'h2B); send(8'h01); send(8'h02);
        send(8'h2D); send(8'h03); send(8'h04); idle(3);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 24) == 0) idle($urandom_range(5, 10));
            if (m_pos == 0 && $urandom_range(0, 9) != 0)
                d = opc_tab[$urandom_range(0, 3)];
            else
                d = 8'($urandom);
            step($urandom_range(0, 3) != 0, d, a);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
